// File: rtl/div_pipe_pkg.sv
// Shared widths and stage payload type for the pipelined restoring divider.
// DIV_ZERO_FLAG_EN adds a divide-by-zero flag to the stage payload.
package div_pipe_pkg;

    localparam int DIV_N = 8;
    localparam int DIV_M = 4;

    typedef struct packed {
        logic             valid;
        logic [DIV_M-1:0] r;
        logic [DIV_N-1:0] q;
        logic [DIV_N-1:0] dividend;
        logic [DIV_M-1:0] divisor;
`ifdef DIV_ZERO_FLAG_EN
        logic             dz;
`endif
    } div_stage_t;

endpackage

// File: rtl/div_cell.sv
// One restoring-division stage: trial subtract on dividend bit N-1-STAGE, select, shift.
// DIV_ZERO_FLAG_EN adds a pass-through divide-by-zero flag register.
module div_cell
    import div_pipe_pkg::*;
#(
    parameter int N     = DIV_N,
    parameter int M     = DIV_M,
    parameter int STAGE = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    input  logic [M-1:0] in_r,
    input  logic [N-1:0] in_q,
    input  logic [N-1:0] in_dvd,
    input  logic [M-1:0] in_dvs,
`ifdef DIV_ZERO_FLAG_EN
    input  logic         in_dz,
    output logic         out_dz,
`endif
    output logic         out_valid,
    output logic [M-1:0] out_r,
    output logic [N-1:0] out_q,
    output logic [N-1:0] out_dvd,
    output logic [M-1:0] out_dvs
);

    logic [M:0]   trial;
    logic         q_bit;
    logic         valid_d, valid_q;
    logic [M-1:0] r_d, r_q;
    logic [N-1:0] quo_d, quo_q;
    logic [N-1:0] dvd_d, dvd_q;
    logic [M-1:0] dvs_d, dvs_q;
`ifdef DIV_ZERO_FLAG_EN
    logic         dz_d, dz_q;
`endif

    always_comb begin
        trial   = {in_r, in_dvd[N-1-STAGE]};
        // A quotient bit is set exactly when the trial difference is non-negative.
        q_bit   = (trial >= {1'b0, in_dvs});
        valid_d = in_valid;
        r_d     = r_q;
        quo_d   = quo_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
`ifdef DIV_ZERO_FLAG_EN
        dz_d    = dz_q;
`endif
        if (in_valid) begin
            r_d   = q_bit ? M'(trial - {1'b0, in_dvs}) : trial[M-1:0];
            quo_d = (in_q << 1) | {{(N-1){1'b0}}, q_bit};
            dvd_d = in_dvd;
            dvs_d = in_dvs;
`ifdef DIV_ZERO_FLAG_EN
            dz_d  = in_dz;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            r_q     <= '0;
            quo_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_r     = r_q;
    assign out_q     = quo_q;
    assign out_dvd   = dvd_q;
    assign out_dvs   = dvs_q;
`ifdef DIV_ZERO_FLAG_EN
    assign out_dz    = dz_q;
`endif

endmodule

// File: rtl/div_pipe.sv
// Pipelined restoring unsigned divider: N stages, one quotient bit per stage, latency N.
// Define DIV_ZERO_FLAG_EN to add the div_zero output aligned with res_rdy.
module div_pipe
    import div_pipe_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         data_rdy,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         res_rdy,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic         div_zero
`endif
);

    // Index 0 is the port side; index i+1 is the register bank of stage i.
    logic         st_valid [0:N];
    logic [M-1:0] st_r     [0:N];
    logic [N-1:0] st_q     [0:N];
    logic [N-1:0] st_dvd   [0:N];
    logic [M-1:0] st_dvs   [0:N];
`ifdef DIV_ZERO_FLAG_EN
    logic         st_dz    [0:N];
`endif

    assign st_valid[0] = data_rdy;
    assign st_r[0]     = '0;
    assign st_q[0]     = '0;
    assign st_dvd[0]   = dividend;
    assign st_dvs[0]   = divisor;
`ifdef DIV_ZERO_FLAG_EN
    assign st_dz[0]    = (divisor == '0);
`endif

    for (genvar i = 0; i < N; i++) begin : g_stage
        div_cell #(
            .N     (N),
            .M     (M),
            .STAGE (i)
        ) u_cell (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (st_valid[i]),
            .in_r      (st_r[i]),
            .in_q      (st_q[i]),
            .in_dvd    (st_dvd[i]),
            .in_dvs    (st_dvs[i]),
`ifdef DIV_ZERO_FLAG_EN
            .in_dz     (st_dz[i]),
            .out_dz    (st_dz[i+1]),
`endif
            .out_valid (st_valid[i+1]),
            .out_r     (st_r[i+1]),
            .out_q     (st_q[i+1]),
            .out_dvd   (st_dvd[i+1]),
            .out_dvs   (st_dvs[i+1])
        );
    end

    assign res_rdy   = st_valid[N];
    assign quotient  = st_q[N];
    assign remainder = st_r[N];
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero  = st_dz[N];
`endif

endmodule

// File: tb/tb_div_pipe.sv
// Self-checking bench for div_pipe (N=8, M=4): directed cases plus random traffic vs a divide model.
// Handshake: res_rdy must pulse exactly N cycles after each data_rdy, with no backpressure.
module tb_div_pipe;
    import div_pipe_pkg::*;

    localparam int N = DIV_N;
    localparam int M = DIV_M;

    logic         clk;
    logic         rstn;
    logic         data_rdy;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         res_rdy;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic         div_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic sb_en = 1'b0;

    div_stage_t exp_q[$];
    div_stage_t last_res;

    div_pipe #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_rdy  (data_rdy),
        .dividend  (dividend),
        .divisor   (divisor),
        .res_rdy   (res_rdy),
        .quotient  (quotient),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero  (div_zero),
`endif
        .remainder (remainder)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer division; divide-by-zero yields all ones / low dividend bits.
    function automatic div_stage_t model(input logic v, input logic [N-1:0] a, input logic [M-1:0] b);
        div_stage_t e;
        e          = '0;
        e.valid    = v;
        e.dividend = a;
        e.divisor  = b;
        if (b == 0) begin
            e.q = '1;
            e.r = a[M-1:0];
        end else begin
            e.q = N'(int'(a) / int'(b));
            e.r = M'(int'(a) % int'(b));
        end
`ifdef DIV_ZERO_FLAG_EN
        e.dz = (b == 0);
`endif
        return e;
    endfunction

    // Capture side: every rising edge out of reset records what the DUT samples.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q.delete();
        end else begin
            exp_q.push_back(model(data_rdy, dividend, divisor));
            if (exp_q.size() > N) void'(exp_q.pop_front());
        end
    end

    // Output side: the capture N-1 edges back is due now; otherwise outputs hold.
    always @(negedge clk) begin
        div_stage_t e;
        if (!rstn) begin
            last_res = '0;
        end else if (sb_en) begin
            e = '0;
            if (exp_q.size() >= N) e = exp_q[exp_q.size()-N];
            check("sb_res_rdy", res_rdy, e.valid);
            if (e.valid) last_res = e;
            check("sb_quotient", quotient, last_res.q);
            check("sb_remainder", remainder, last_res.r);
`ifdef DIV_ZERO_FLAG_EN
            check("sb_div_zero", div_zero, last_res.dz);
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [N-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        data_rdy = v;
        dividend = a;
        divisor  = b;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) drive(1'b0, '0, '0);
    endtask

    task automatic wait_neg(input int cycles);
        for (int k = 0; k < cycles; k++) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic rdy, input int q, input int r);
        check({tag, "_rdy"}, res_rdy, rdy);
        check({tag, "_q"}, quotient, q);
        check({tag, "_r"}, remainder, r);
    endtask

    task automatic single(input string tag, input int a, input int b, input int q, input int r);
        drive(1'b1, N'(a), M'(b));
        idle(1);
        wait_neg(N - 2);
        check({tag, "_early_rdy"}, res_rdy, 0);
        wait_neg(1);
        expect_out(tag, 1'b1, q, r);
        wait_neg(1);
        check({tag, "_pulse_end"}, res_rdy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ops;
        rstn     = 1'b0;
        data_rdy = 1'b0;
        dividend = '0;
        divisor  = '0;
        wait_neg(2);
        expect_out("reset", 1'b0, 0, 0);
`ifdef DIV_ZERO_FLAG_EN
        check("reset_dz", div_zero, 0);
`endif
        rstn  = 1'b1;
        sb_en = 1'b1;

        single("single_100_7", 100, 7, 14, 2);
        single("edge_255_1", 255, 1, 255, 0);
        single("edge_5_15", 5, 15, 0, 5);
        single("edge_15_15", 15, 15, 1, 0);

        // Divide by zero followed by an ordinary op.
        drive(1'b1, 8'd200, 4'd0);
        drive(1'b1, 8'd9, 4'd3);
        idle(1);
        wait_neg(N - 2);
        expect_out("dz_200_0", 1'b1, 255, 8);
`ifdef DIV_ZERO_FLAG_EN
        check("dz_flag_set", div_zero, 1);
`endif
        wait_neg(1);
        expect_out("dz_next_9_3", 1'b1, 3, 0);
`ifdef DIV_ZERO_FLAG_EN
        check("dz_flag_clear", div_zero, 0);
`endif

        // Streaming: three back-to-back, two-cycle gap, one more.
        idle(2);
        drive(1'b1, 8'd100, 4'd7);
        drive(1'b1, 8'd50, 4'd6);
        drive(1'b1, 8'd13, 4'd13);
        idle(2);
        drive(1'b1, 8'd77, 4'd5);
        idle(1);
        wait_neg(2);
        expect_out("stream0", 1'b1, 14, 2);
        wait_neg(1);
        expect_out("stream1", 1'b1, 8, 2);
        wait_neg(1);
        expect_out("stream2", 1'b1, 1, 0);
        wait_neg(1);
        expect_out("gap0", 1'b0, 1, 0);
        wait_neg(1);
        expect_out("gap1", 1'b0, 1, 0);
        wait_neg(1);
        expect_out("stream3", 1'b1, 15, 2);

        // Reset mid-flight: two ops accepted, reset four cycles later.
        idle(2);
        drive(1'b1, 8'd100, 4'd7);
        drive(1'b1, 8'd50, 4'd6);
        idle(3);
        #2 rstn = 1'b0;
        #1;
        expect_out("midrst", 1'b0, 0, 0);
`ifdef DIV_ZERO_FLAG_EN
        check("midrst_dz", div_zero, 0);
`endif
        wait_neg(2);
        #2 rstn = 1'b1;
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            check("post_rst_rdy", res_rdy, 0);
        end

        // Random traffic with nonzero divisors and random gaps.
        ops = 0;
        while (ops < 10000) begin
            if ($urandom_range(0, 3) != 0) begin
                drive(1'b1, N'($urandom_range(0, (1 << N) - 1)), M'($urandom_range(1, (1 << M) - 1)));
                ops++;
            end else begin
                drive(1'b0, N'($urandom_range(0, (1 << N) - 1)), M'($urandom_range(0, (1 << M) - 1)));
            end
        end
        idle(N + 2);

        sb_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
